// File: rtl/tx_core.sv
// tx_core: UART transmit engine. A byte FIFO feeds a one-hot frame FSM that
// shifts start, 8 data bits, optional parity and stop onto Tx_o, one bit per
// BaudSig_i pulse. Build option: define TX_TWO_STOP_EN for two stop bits.
module tx_core #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Data_i,
  input  logic       n_We_i,
  input  logic       n_Clr_i,
  input  logic       p_Enable_i,
  input  logic       p_ParityEnable_i,
  input  logic       ParityMethod_i,
  input  logic       p_BigEnd_i,
  input  logic       BaudSig_i,
  output logic       p_Empty_o,
  output logic       p_Full_o,
  output logic       p_Over_o,
  output logic [7:0] TxFifoLevel_o,
  output logic       p_Busy_o,
  output logic       p_ByteSent_o,
  output logic       Tx_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [4:0] {
    INTERVAL  = 5'b00001,
    STARTBIT  = 5'b00010,
    DATABITS  = 5'b00100,
    PARITYBIT = 5'b01000,
    STOPBIT   = 5'b10000
  } txState_t;

  txState_t           state;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [7:0]         level;
  logic               over;
  logic [7:0]         shiftReg;
  logic [2:0]         bitCnt;
  logic               bigEndLat;
  logic               parityEnLat;
  logic               parityBit;
  logic               txReg;
  logic               busy;
  logic               byteSent;
  logic               isEmpty;
  logic               isFull;
  logic               wrReq;
  logic               doWrite;
  logic               doPop;
  logic               lastStop;
`ifdef TX_TWO_STOP_EN
  logic               stopSecond;
`endif

  // FIFO status and the pop/write handshakes for this cycle
  always_comb begin
    isEmpty  = (level == 8'd0);
    isFull   = (level == 8'(FIFO_DEPTH));
    wrReq    = !n_We_i && n_Clr_i;
    doWrite  = wrReq && !isFull;
`ifdef TX_TWO_STOP_EN
    lastStop = (state == STOPBIT) && stopSecond;
`else
    lastStop = (state == STOPBIT);
`endif
    doPop    = BaudSig_i && p_Enable_i && !isEmpty &&
               ((state == INTERVAL) || lastStop);
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= Data_i;
  end

  // FIFO pointers, level and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      over  <= 1'b0;
    end else if (!n_Clr_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      over  <= 1'b0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)   rdPtr <= rdPtr + PTR_W'(1);
      if (wrReq && isFull) over <= 1'b1;
      unique case ({doWrite, doPop})
        2'b10:   level <= level + 8'd1;
        2'b01:   level <= level - 8'd1;
        default: level <= level;
      endcase
    end
  end

  // Frame FSM with registered line, busy and byte-sent outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= INTERVAL;
      shiftReg    <= '0;
      bitCnt      <= '0;
      bigEndLat   <= 1'b0;
      parityEnLat <= 1'b0;
      parityBit   <= 1'b0;
      txReg       <= 1'b1;
      busy        <= 1'b0;
      byteSent    <= 1'b0;
`ifdef TX_TWO_STOP_EN
      stopSecond  <= 1'b0;
`endif
    end else begin
      byteSent <= 1'b0;
      if (BaudSig_i) begin
        if (lastStop) byteSent <= 1'b1;
        if (doPop) begin
          // load next byte and freeze its framing config
          state       <= STARTBIT;
          shiftReg    <= mem[rdPtr];
          bigEndLat   <= p_BigEnd_i;
          parityEnLat <= p_ParityEnable_i;
          parityBit   <= (^mem[rdPtr]) ^ ParityMethod_i;
          txReg       <= 1'b0;
          busy        <= 1'b1;
`ifdef TX_TWO_STOP_EN
          stopSecond  <= 1'b0;
`endif
        end else begin
          unique case (state)
            INTERVAL: begin
              txReg <= 1'b1;
            end
            STARTBIT: begin
              state    <= DATABITS;
              bitCnt   <= 3'd0;
              txReg    <= bigEndLat ? shiftReg[7] : shiftReg[0];
              shiftReg <= bigEndLat ? {shiftReg[6:0], 1'b0} : {1'b0, shiftReg[7:1]};
            end
            DATABITS: begin
              if (bitCnt == 3'd7) begin
                if (parityEnLat) begin
                  state <= PARITYBIT;
                  txReg <= parityBit;
                end else begin
                  state <= STOPBIT;
                  txReg <= 1'b1;
                end
              end else begin
                bitCnt   <= bitCnt + 3'd1;
                txReg    <= bigEndLat ? shiftReg[7] : shiftReg[0];
                shiftReg <= bigEndLat ? {shiftReg[6:0], 1'b0} : {1'b0, shiftReg[7:1]};
              end
            end
            PARITYBIT: begin
              state <= STOPBIT;
              txReg <= 1'b1;
            end
            STOPBIT: begin
              if (lastStop) begin
                state <= INTERVAL;
                txReg <= 1'b1;
                busy  <= 1'b0;
              end
`ifdef TX_TWO_STOP_EN
              else begin
                stopSecond <= 1'b1;
              end
`endif
            end
            default: begin
              state <= INTERVAL;
              txReg <= 1'b1;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign p_Empty_o     = isEmpty;
  assign p_Full_o      = isFull;
  assign p_Over_o      = over;
  assign TxFifoLevel_o = level;
  assign p_Busy_o      = busy;
  assign p_ByteSent_o  = byteSent;
  assign Tx_o          = txReg;

endmodule

// File: tb/tb_tx_core.sv
// tb_tx_core: directed bench for tx_core (default build, depth 16, one stop bit).
module tb_tx_core;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       nWe;
  logic       nClr;
  logic       en;
  logic       parEn;
  logic       method;
  logic       bigEnd;
  logic       baud;
  logic       empty;
  logic       full;
  logic       over;
  logic [7:0] level;
  logic       busy;
  logic       byteSent;
  logic       txW;

  int checks = 0;
  int failures = 0;

  tx_core #(.FIFO_DEPTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .Data_i           (data),
    .n_We_i           (nWe),
    .n_Clr_i          (nClr),
    .p_Enable_i       (en),
    .p_ParityEnable_i (parEn),
    .ParityMethod_i   (method),
    .p_BigEnd_i       (bigEnd),
    .BaudSig_i        (baud),
    .p_Empty_o        (empty),
    .p_Full_o         (full),
    .p_Over_o         (over),
    .TxFifoLevel_o    (level),
    .p_Busy_o         (busy),
    .p_ByteSent_o     (byteSent),
    .Tx_o             (txW)
  );

  // clock, 10 time units
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // baud pulse: one clk high every four clks, driven on the falling edge
  initial begin
    baud = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud = 1'b1;
      @(negedge clk);
      baud = 1'b0;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic writeByte(input logic [7:0] b);
    @(negedge clk);
    data = b;
    nWe  = 1'b0;
    @(negedge clk);
    nWe  = 1'b1;
  endtask

  // advance to 1 time unit after the next clk edge that samples a baud pulse
  task automatic waitBaud();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(posedge clk);
      if (baud) seen = 1'b1;
    end
    #1;
    if (!seen) checkVal("baud_timeout", 32'd0, 32'd1);
  endtask

  task automatic collectFrame(input int n, output logic [31:0] f);
    f = '0;
    for (int i = 0; i < n; i++) begin
      waitBaud();
      f = {f[30:0], txW};
    end
  endtask

  // after the stop bit: byte-sent pulse, back to idle
  task automatic checkFrameEnd(input string tag);
    waitBaud();
    checkVal({tag, "_sent"}, 32'(byteSent), 32'd1);
    checkVal({tag, "_idle"}, 32'(busy), 32'd0);
    checkVal({tag, "_tx"}, 32'(txW), 32'd1);
  endtask

  logic [31:0] frame;
  int zeros;
  int sents;

  initial begin
    rst = 1'b0; data = 8'h00; nWe = 1'b1; nClr = 1'b1;
    en = 1'b0; parEn = 1'b0; method = 1'b0; bigEnd = 1'b0;
    #22;
    checkVal("rst_tx",    32'(txW),      32'd1);
    checkVal("rst_empty", 32'(empty),    32'd1);
    checkVal("rst_full",  32'(full),     32'd0);
    checkVal("rst_over",  32'(over),     32'd0);
    checkVal("rst_level", 32'(level),    32'd0);
    checkVal("rst_busy",  32'(busy),     32'd0);
    checkVal("rst_sent",  32'(byteSent), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // little end, no parity, 0x01
    en = 1'b1;
    writeByte(8'h01);
    collectFrame(10, frame);
    checkVal("le_frame", frame, 32'b0100000001);
    checkVal("le_sent_early", 32'(byteSent), 32'd0);
    checkFrameEnd("le");

    // big end, no parity, 0x01
    bigEnd = 1'b1;
    writeByte(8'h01);
    collectFrame(10, frame);
    checkVal("be_frame", frame, 32'b0000000011);
    checkFrameEnd("be");

    // parity even, 0x07 little end: parity bit 1
    bigEnd = 1'b0; parEn = 1'b1; method = 1'b0;
    writeByte(8'h07);
    collectFrame(11, frame);
    checkVal("par_even", frame, 32'b01110000011);
    checkFrameEnd("pe");

    // parity odd, 0x07: parity bit 0
    method = 1'b1;
    writeByte(8'h07);
    collectFrame(11, frame);
    checkVal("par_odd", frame, 32'b01110000001);
    checkFrameEnd("po");

    // three queued bytes go out back to back
    parEn = 1'b0; method = 1'b0; en = 1'b0;
    writeByte(8'h55);
    writeByte(8'hF0);
    writeByte(8'h81);
    checkVal("q3_level", 32'(level), 32'd3);
    @(negedge clk);
    en = 1'b1;
    frame = '0;
    for (int i = 0; i < 30; i++) begin
      waitBaud();
      frame = {frame[30:0], txW};
      if (i == 0)  checkVal("q3_lvl2", 32'(level), 32'd2);
      if (i == 10) checkVal("q3_lvl1", 32'(level), 32'd1);
      if (i == 20) checkVal("q3_lvl0", 32'(level), 32'd0);
    end
    checkVal("q3_frames", frame, {2'b00, 10'b0101010101, 10'b0000011111, 10'b0100000011});
    checkFrameEnd("q3");

    // overflow with transmit disabled, then flush
    en = 1'b0;
    for (int i = 0; i < 17; i++) writeByte(8'(i));
    checkVal("ovf_level", 32'(level), 32'd16);
    checkVal("ovf_full",  32'(full),  32'd1);
    checkVal("ovf_over",  32'(over),  32'd1);
    checkVal("ovf_empty", 32'(empty), 32'd0);
    @(negedge clk);
    nClr = 1'b0;
    @(negedge clk);
    nClr = 1'b1;
    checkVal("clr_level", 32'(level), 32'd0);
    checkVal("clr_over",  32'(over),  32'd0);
    checkVal("clr_empty", 32'(empty), 32'd1);
    checkVal("clr_full",  32'(full),  32'd0);

    // reset in the middle of data bits
    writeByte(8'h00);
    writeByte(8'h00);
    @(negedge clk);
    en = 1'b1;
    waitBaud();
    waitBaud();
    waitBaud();
    checkVal("mid_tx",   32'(txW),  32'd0);
    checkVal("mid_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkVal("arst_tx",    32'(txW),   32'd1);
    checkVal("arst_busy",  32'(busy),  32'd0);
    checkVal("arst_level", 32'(level), 32'd0);
    checkVal("arst_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    zeros = 0;
    sents = 0;
    for (int i = 0; i < 15; i++) begin
      waitBaud();
      if (txW == 1'b0) zeros++;
      if (byteSent) sents++;
    end
    checkVal("post_rst_zeros", 32'(zeros), 32'd0);
    checkVal("post_rst_sent",  32'(sents), 32'd0);
    checkVal("post_rst_busy",  32'(busy),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
